morse_arbiter: RTL and testbench
================================

MORSE_ARBITER -- requirements
Module: morse_arbiter

Interface
REQ-001 Parameter MAX_CHARS, default 15: characters per grant before forced release (1-15).
REQ-002 Parameter GAP_CHARS, default 1: space characters (len 0) issued after each released grant (0-3).
REQ-003 Parameter IDLE_TMO, default 255: cycles a grant is held with no requester character before release (1-255).
REQ-004 clock  in  1  single rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req0_vald / req1_vald  in  1  requester N presents a character.
REQ-007 req0_code / req1_code  in  8  requester N Morse code bits.
REQ-008 req0_len / req1_len  in  4  requester N symbol count (0 = word space).
REQ-009 req0_last / req1_last  in  1  character ends requester N's message.
REQ-010 req0_next / req1_next  out  1  one-cycle pulse: requester N's character captured.
REQ-011 char_vald  out  1  character valid to transmitter.
REQ-012 charcode_data  out  8  code to transmitter.
REQ-013 charlen_data  out  4  length to transmitter.
REQ-014 char_next  in  1  transmitter pulse: current character finished.
REQ-015 grant  out  2  one-hot owner (bit N = requester N); 00 when unowned.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 All outputs shall be registered; states IDLE, SEND, FETCH, GAP.
REQ-018 IDLE: grant=00; if any reqN_vald high, winner chosen by priority pointer, its code/len/last captured, grant set, reqN_next pulsed that cycle, char count=1, go SEND.
REQ-019 Priority pointer: req0 after reset; toggles to the other requester on every grant release; both valid in IDLE -> pointer side wins.
REQ-020 SEND: char_vald=1, charcode_data/charlen_data hold captured values, stable until char_next sampled high.
REQ-021 At the edge sampling char_next=1 in SEND, char_vald shall clear; it stays low at least one full cycle before the next character.
REQ-022 From SEND on char_next: captured last=1 or count=MAX_CHARS -> release; else go FETCH, timeout counter cleared.
REQ-023 FETCH: grant held; granted reqN_vald high -> capture, pulse reqN_next, count+1, go SEND; other requester ignored.
REQ-024 FETCH: timeout counter increments each cycle without granted vald; reaching IDLE_TMO -> release.
REQ-025 Release: GAP_CHARS>0 -> GAP with grant cleared; else IDLE; pointer toggles at release.
REQ-026 GAP: issue GAP_CHARS characters code=00h, len=0 using REQ-020/021 handshake; after last char_next -> IDLE.
REQ-027 reqN_next shall never pulse outside a capture; never both in one cycle; never for an ungranted requester.
REQ-028 char_next outside SEND/GAP-issue shall be ignored.
REQ-029 req len values 9-15 and len=0 from requesters shall pass through unmodified as ordinary characters.
REQ-030 Char count 4-bit, timeout 8-bit, gap 2-bit; none wraps (each cleared on use).

Reset
REQ-031 reset low shall immediately force state IDLE, char_vald=0, charcode_data=00h, charlen_data=0, grant=00, busy=0, reqN_next=0, pointer=req0, all counters 0.
REQ-032 reset asserted mid-character shall abandon the character; after release the first character is a fresh arbitration.

Verification
REQ-033 Both vald high in IDLE after reset, req0 {code A0h, len 2, last 1} -> grant=01, req0_next one pulse, char_vald=1 with A0h/2; on char_next one GAP char 00h/0; then req1 granted (grant=10).
REQ-034 req1 sends 3 chars, last on third, char_next each 20 cycles later -> exactly 3 req1_next pulses, char_vald low >=1 cycle between chars, then 1 gap char, busy low.
REQ-035 MAX_CHARS=2, req0 streams last=0 -> release after 2nd char_next, gap char issued, req1 (waiting) granted next.
REQ-036 IDLE_TMO=4, req0 drops vald after 1st char -> grant released 4 cycles into FETCH, GAP entered, pointer toggled to req1.
REQ-037 reset low during SEND -> char_vald/grant/busy 0 same cycle asynchronously; after reset high, req1 only valid -> req1 granted.
REQ-038 char_next pulsed in IDLE and FETCH -> no state, count or output change.

Source files
------------

// File: rtl/morse_arbiter.sv
// morse_arbiter: two-requester arbiter feeding one Morse transmitter,
// with a per-grant character cap, idle timeout and inter-message gap.
module morse_arbiter #(
  parameter int unsigned MAX_CHARS = 15,
  parameter int unsigned GAP_CHARS = 1,
  parameter int unsigned IDLE_TMO  = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_vald,
  input  logic [7:0] req0_code,
  input  logic [3:0] req0_len,
  input  logic       req0_last,
  output logic       req0_next,
  input  logic       req1_vald,
  input  logic [7:0] req1_code,
  input  logic [3:0] req1_len,
  input  logic       req1_last,
  output logic       req1_next,
  output logic       char_vald,
  output logic [7:0] charcode_data,
  output logic [3:0] charlen_data,
  input  logic       char_next,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE, SEND, FETCH, GAP
  } state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_CHARS);
  localparam logic [1:0] GAP_C = 2'(GAP_CHARS);
  localparam logic [7:0] TMO_C = 8'(IDLE_TMO);

  state_t     state, state_d;
  logic       vald_d;
  logic [7:0] code_d;
  logic [3:0] len_d;
  logic       last_q, last_d;
  logic [1:0] grant_d;
  logic       next0_d, next1_d;
  logic       busy_d;
  logic       ptr, ptr_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] tmo, tmo_d;
  logic [1:0] gap, gap_d;
  logic       capture, release_g;
  logic       sel1, own_vald;
  logic [7:0] src_code;
  logic [3:0] src_len;
  logic       src_last;

  // IDLE arbitrates by pointer; FETCH only listens to the owner
  assign sel1 = (state == IDLE)
              ? (req1_vald & (~req0_vald | ptr))
              : grant[1];
  assign own_vald = grant[1] ? req1_vald : req0_vald;
  assign src_code = sel1 ? req1_code : req0_code;
  assign src_len  = sel1 ? req1_len  : req0_len;
  assign src_last = sel1 ? req1_last : req0_last;

  always_comb begin
    state_d   = state;
    vald_d    = char_vald;
    code_d    = charcode_data;
    len_d     = charlen_data;
    last_d    = last_q;
    grant_d   = grant;
    next0_d   = 1'b0;
    next1_d   = 1'b0;
    ptr_d     = ptr;
    cnt_d     = cnt;
    tmo_d     = tmo;
    gap_d     = gap;
    capture   = 1'b0;
    release_g = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_vald | req1_vald) begin
          capture = 1'b1;
          grant_d = sel1 ? 2'b10 : 2'b01;
          cnt_d   = 4'd1;
        end
      end
      SEND: begin
        if (char_next) begin
          vald_d = 1'b0;
          if (last_q || cnt == MAX_C) begin
            release_g = 1'b1;
          end else begin
            state_d = FETCH;
            tmo_d   = 8'd0;
          end
        end
      end
      FETCH: begin
        if (own_vald) begin
          capture = 1'b1;
          cnt_d   = cnt + 4'd1;
        end else if (tmo + 8'd1 == TMO_C) begin
          release_g = 1'b1;
        end else begin
          tmo_d = tmo + 8'd1;
        end
      end
      GAP: begin
        if (!char_vald) begin
          vald_d = 1'b1;
        end else if (char_next) begin
          vald_d = 1'b0;
          if (gap + 2'd1 == GAP_C) begin
            state_d = IDLE;
            gap_d   = 2'd0;
          end else begin
            gap_d = gap + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d = SEND;
      vald_d  = 1'b1;
      code_d  = src_code;
      len_d   = src_len;
      last_d  = src_last;
      next0_d = ~sel1;
      next1_d = sel1;
    end
    // pointer moves to whoever did not own the released grant
    if (release_g) begin
      state_d = (GAP_C != 2'd0) ? GAP : IDLE;
      grant_d = 2'b00;
      ptr_d   = grant[0];
      cnt_d   = 4'd0;
      tmo_d   = 8'd0;
      gap_d   = 2'd0;
      last_d  = 1'b0;
      code_d  = 8'h00;
      len_d   = 4'd0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      char_vald     <= 1'b0;
      charcode_data <= 8'h00;
      charlen_data  <= 4'd0;
      last_q        <= 1'b0;
      grant         <= 2'b00;
      req0_next     <= 1'b0;
      req1_next     <= 1'b0;
      busy          <= 1'b0;
      ptr           <= 1'b0;
      cnt           <= 4'd0;
      tmo           <= 8'd0;
      gap           <= 2'd0;
    end else begin
      state         <= state_d;
      char_vald     <= vald_d;
      charcode_data <= code_d;
      charlen_data  <= len_d;
      last_q        <= last_d;
      grant         <= grant_d;
      req0_next     <= next0_d;
      req1_next     <= next1_d;
      busy          <= busy_d;
      ptr           <= ptr_d;
      cnt           <= cnt_d;
      tmo           <= tmo_d;
      gap           <= gap_d;
    end
  end

endmodule

// File: tb/tb_morse_arbiter.sv
// tb_morse_arbiter: directed scoreboard bench; instance a uses default
// parameters, instance b uses MAX_CHARS=2 / IDLE_TMO=4.
module tb_morse_arbiter;

  logic       clock;
  logic       reset;
  logic       r0_vald, r0_last, r1_vald, r1_last;
  logic [7:0] r0_code, r1_code;
  logic [3:0] r0_len, r1_len;
  logic       char_next, tx_pulse, man_pulse;

  logic       a_n0, a_n1, a_vald, a_busy;
  logic [7:0] a_code;
  logic [3:0] a_len;
  logic [1:0] a_grant;
  logic       b_n0, b_n1, b_vald, b_busy;
  logic [7:0] b_code;
  logic [3:0] b_len;
  logic [1:0] b_grant;

  logic       sel;
  logic       m_n0, m_n1, m_vald, m_busy;
  logic [7:0] m_code;
  logic [3:0] m_len;
  logic [1:0] m_grant;

  int vectors = 0;
  int miscompares = 0;
  int p0 = 0;
  int p1 = 0;
  int tx_dly = 3;
  bit tx_en = 0;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] len;
    logic [1:0] grant;
  } exp_t;
  exp_t q[$];

  assign char_next = tx_pulse | man_pulse;
  assign m_n0    = sel ? b_n0    : a_n0;
  assign m_n1    = sel ? b_n1    : a_n1;
  assign m_vald  = sel ? b_vald  : a_vald;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_code  = sel ? b_code  : a_code;
  assign m_len   = sel ? b_len   : a_len;
  assign m_grant = sel ? b_grant : a_grant;

  morse_arbiter dut_a (
    .clock(clock), .reset(reset),
    .req0_vald(r0_vald), .req0_code(r0_code),
    .req0_len(r0_len), .req0_last(r0_last),
    .req0_next(a_n0),
    .req1_vald(r1_vald), .req1_code(r1_code),
    .req1_len(r1_len), .req1_last(r1_last),
    .req1_next(a_n1),
    .char_vald(a_vald), .charcode_data(a_code),
    .charlen_data(a_len), .char_next(char_next),
    .grant(a_grant), .busy(a_busy)
  );

  morse_arbiter #(
    .MAX_CHARS(2), .GAP_CHARS(1), .IDLE_TMO(4)
  ) dut_b (
    .clock(clock), .reset(reset),
    .req0_vald(r0_vald), .req0_code(r0_code),
    .req0_len(r0_len), .req0_last(r0_last),
    .req0_next(b_n0),
    .req1_vald(r1_vald), .req1_code(r1_code),
    .req1_len(r1_len), .req1_last(r1_last),
    .req1_next(b_n1),
    .char_vald(b_vald), .charcode_data(b_code),
    .charlen_data(b_len), .char_next(char_next),
    .grant(b_grant), .busy(b_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  task automatic expect_char(input logic [7:0] c,
                             input logic [3:0] l,
                             input logic [1:0] g);
    q.push_back({c, l, g});
  endtask

  // scoreboard monitor: every new character and every next pulse
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (m_vald && !prev) begin
        if (q.size() == 0) begin
          check("unexpected_char",
                {18'd0, m_code, m_len, m_grant}, 32'hFFFF);
        end else begin
          e = q.pop_front();
          check("char", {18'd0, m_code, m_len, m_grant},
                {18'd0, e});
        end
      end
      prev = m_vald;
      if (m_n0 || m_n1) begin
        check("next_excl", {31'd0, m_n0 & m_n1}, 0);
        check("next_granted",
              {30'd0, {m_n1, m_n0} & ~m_grant}, 0);
        if (m_n0) p0++;
        if (m_n1) p1++;
      end
    end
  end

  // transmitter model: finishes each character tx_dly cycles later
  initial begin
    tx_pulse = 1'b0;
    forever begin
      @(negedge clock);
      if (m_vald && tx_en) begin
        repeat (tx_dly - 1) @(negedge clock);
        tx_pulse = 1'b1;
        @(negedge clock);
        tx_pulse = 1'b0;
      end
    end
  end

  task automatic send_char(input int n,
                           input logic [7:0] c,
                           input logic [3:0] l,
                           input logic last);
    int t;
    logic hit;
    t = 0;
    if (n == 0) begin
      r0_vald = 1; r0_code = c; r0_len = l; r0_last = last;
    end else begin
      r1_vald = 1; r1_code = c; r1_len = l; r1_last = last;
    end
    do begin
      @(negedge clock);
      t++;
      hit = (n == 0) ? m_n0 : m_n1;
    end while (!hit && t < 400);
    check(n == 0 ? "next0_seen" : "next1_seen", {31'd0, hit}, 1);
    check(n == 0 ? "grant0" : "grant1", {30'd0, m_grant},
          n == 0 ? 32'd1 : 32'd2);
    if (n == 0) r0_vald = 0;
    else        r1_vald = 0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((m_busy || m_vald) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check(nm, {31'd0, m_busy}, 0);
  endtask

  task automatic wait_vald(input string nm);
    int t;
    t = 0;
    while (!m_vald && t < 100) begin
      @(negedge clock);
      t++;
    end
    check(nm, {31'd0, m_vald}, 1);
  endtask

  task automatic pulse_next();
    @(negedge clock);
    man_pulse = 1'b1;
    @(negedge clock);
    man_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int b0, b1, t;
    reset = 0; sel = 0; man_pulse = 0;
    r0_vald = 0; r0_code = 0; r0_len = 0; r0_last = 0;
    r1_vald = 0; r1_code = 0; r1_len = 0; r1_last = 0;
    repeat (2) @(negedge clock);
    check("rst_vald", {31'd0, m_vald}, 0);
    check("rst_code", {24'd0, m_code}, 0);
    check("rst_len", {28'd0, m_len}, 0);
    check("rst_grant", {30'd0, m_grant}, 0);
    check("rst_busy", {31'd0, m_busy}, 0);
    check("rst_next", {30'd0, m_n1, m_n0}, 0);
    reset = 1;
    @(negedge clock);

    // both valid after reset: req0 first, gap, then req1
    tx_en = 1; tx_dly = 3;
    b0 = p0; b1 = p1;
    expect_char(8'hA0, 4'd2, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    expect_char(8'hB1, 4'd3, 2'b10);
    expect_char(8'h00, 4'd0, 2'b00);
    fork
      send_char(0, 8'hA0, 4'd2, 1'b1);
      send_char(1, 8'hB1, 4'd3, 1'b1);
    join
    wait_idle("both_idle");
    check("both_p0", p0 - b0, 1);
    check("both_p1", p1 - b1, 1);

    // three-character message, slow transmitter, odd lengths
    tx_dly = 20;
    b1 = p1;
    expect_char(8'h11, 4'd1, 2'b10);
    expect_char(8'h22, 4'd0, 2'b10);
    expect_char(8'h33, 4'd12, 2'b10);
    expect_char(8'h00, 4'd0, 2'b00);
    send_char(1, 8'h11, 4'd1, 1'b0);
    send_char(1, 8'h22, 4'd0, 1'b0);
    send_char(1, 8'h33, 4'd12, 1'b1);
    wait_idle("msg3_idle");
    check("msg3_p1", p1 - b1, 3);

    // stray char_next in IDLE and FETCH is ignored
    tx_en = 0;
    pulse_next();
    check("idle_nx_busy", {31'd0, m_busy}, 0);
    check("idle_nx_vald", {31'd0, m_vald}, 0);
    check("idle_nx_grant", {30'd0, m_grant}, 0);
    expect_char(8'h5A, 4'd4, 2'b01);
    send_char(0, 8'h5A, 4'd4, 1'b0);
    repeat (2) @(negedge clock);
    pulse_next();
    pulse_next();
    check("fetch_nx_vald", {31'd0, m_vald}, 0);
    check("fetch_nx_grant", {30'd0, m_grant}, 1);
    check("fetch_nx_busy", {31'd0, m_busy}, 1);
    check("fetch_nx_code", {24'd0, m_code}, 32'h5A);
    expect_char(8'h5B, 4'd5, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    send_char(0, 8'h5B, 4'd5, 1'b1);
    repeat (2) @(negedge clock);
    pulse_next();
    wait_vald("gap_vald");
    pulse_next();
    wait_idle("stray_idle");

    // asynchronous reset in the middle of a character
    expect_char(8'h77, 4'd1, 2'b01);
    send_char(0, 8'h77, 4'd1, 1'b1);
    repeat (2) @(negedge clock);
    #2 reset = 0;
    #1;
    check("arst_vald", {31'd0, m_vald}, 0);
    check("arst_grant", {30'd0, m_grant}, 0);
    check("arst_busy", {31'd0, m_busy}, 0);
    check("arst_code", {24'd0, m_code}, 0);
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    tx_en = 1; tx_dly = 4;
    expect_char(8'h88, 4'd2, 2'b10);
    expect_char(8'h00, 4'd0, 2'b00);
    send_char(1, 8'h88, 4'd2, 1'b1);
    wait_idle("arst_idle");

    // character cap of 2 forces release; waiting req1 goes next
    sel = 1; tx_dly = 3;
    do_reset();
    expect_char(8'hC1, 4'd1, 2'b01);
    expect_char(8'hC2, 4'd2, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    expect_char(8'hD1, 4'd4, 2'b10);
    expect_char(8'h00, 4'd0, 2'b00);
    expect_char(8'hC3, 4'd3, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    fork
      begin
        send_char(0, 8'hC1, 4'd1, 1'b0);
        send_char(0, 8'hC2, 4'd2, 1'b0);
        send_char(0, 8'hC3, 4'd3, 1'b1);
      end
      send_char(1, 8'hD1, 4'd4, 1'b1);
    join
    wait_idle("cap_idle");

    // idle timeout of 4 cycles in FETCH
    do_reset();
    expect_char(8'hE1, 4'd1, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    send_char(0, 8'hE1, 4'd1, 1'b0);
    t = 0;
    while (m_vald && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("tmo_fetch", {31'd0, m_vald}, 0);
    repeat (3) @(negedge clock);
    check("tmo_hold", {30'd0, m_grant}, 1);
    @(negedge clock);
    check("tmo_rel", {30'd0, m_grant}, 0);
    check("tmo_busy", {31'd0, m_busy}, 1);
    wait_idle("tmo_idle");
    expect_char(8'hF1, 4'd2, 2'b10);
    expect_char(8'h00, 4'd0, 2'b00);
    expect_char(8'hF2, 4'd3, 2'b01);
    expect_char(8'h00, 4'd0, 2'b00);
    fork
      send_char(0, 8'hF2, 4'd3, 1'b1);
      send_char(1, 8'hF1, 4'd2, 1'b1);
    join
    wait_idle("ptr_idle");

    repeat (3) @(negedge clock);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
